// File: rtl/ras_circ_stack.sv
// ras_circ_stack: parametrised circular return-address stack.
// Oldest entry is overwritten on overflow. Push+pop together replaces the top entry.
// Optional pointer checkpoint/restore is built when CVA6_RAS_CHECKPOINT_EN is defined.
module ras_circ_stack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned CK_W  = PTR_W + CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [VLEN-1:0]  data_i,
    output logic [VLEN-1:0]  top_o,
    output logic             top_valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic [CK_W-1:0]  ckpt_o,
    input  logic             restore_i,
    input  logic [CK_W-1:0]  ckpt_i
);

    logic [VLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos, tos_n;
    logic [CNT_W-1:0] count, count_n;
    logic             ovf_n, unf_n;
    logic             we;
    logic [PTR_W-1:0] waddr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] x);
        return (x == PTR_W'(DEPTH - 1)) ? '0 : x + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] x);
        return (x == '0) ? PTR_W'(DEPTH - 1) : x - PTR_W'(1);
    endfunction

    // Next-state decode: flush > restore > push/pop; lower-priority requests are dropped
    always_comb begin
        tos_n   = tos;
        count_n = count;
        we      = 1'b0;
        waddr   = tos;
        ovf_n   = 1'b0;
        unf_n   = 1'b0;
        if (flush_i) begin
            tos_n   = '0;
            count_n = '0;
        end
`ifdef CVA6_RAS_CHECKPOINT_EN
        else if (restore_i) begin
            {count_n, tos_n} = ckpt_i;
        end
`endif
        else if (push_i && pop_i) begin
            // Replace the top entry in place
            we    = 1'b1;
            waddr = tos;
            if (count == '0) count_n = CNT_W'(1);
        end else if (push_i) begin
            tos_n = ptr_inc(tos);
            we    = 1'b1;
            waddr = ptr_inc(tos);
            if (count == CNT_W'(DEPTH)) ovf_n = 1'b1;
            else                        count_n = count + CNT_W'(1);
        end else if (pop_i) begin
            if (count != '0) begin
                tos_n   = ptr_dec(tos);
                count_n = count - CNT_W'(1);
            end else begin
                unf_n = 1'b1;
            end
        end
    end

    // State and pulse registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos         <= '0;
            count       <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            tos         <= tos_n;
            count       <= count_n;
            overflow_o  <= ovf_n;
            underflow_o <= unf_n;
        end
    end

    // Entry storage; cleared on reset, untouched by flush and restore
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= data_i;
        end
    end

    assign top_o       = mem[tos];
    assign top_valid_o = (count != '0);
    assign count_o     = count;

`ifdef CVA6_RAS_CHECKPOINT_EN
    assign ckpt_o = {count, tos};
`else
    // Checkpoint ports are kept for a stable port list but carry no function here
    logic unused_ckpt;
    assign unused_ckpt = ^{restore_i, ckpt_i};
    assign ckpt_o      = '0;
`endif

endmodule

// File: tb/tb_ras_circ_stack.sv
// Directed bench for ras_circ_stack: one DEPTH=4 and one DEPTH=3 instance.
// Expectations adapt to whether CVA6_RAS_CHECKPOINT_EN is defined.
module tb_ras_circ_stack;

`ifdef CVA6_RAS_CHECKPOINT_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // DEPTH=4 instance
    logic        a_rst, a_flush, a_push, a_pop, a_restore;
    logic [63:0] a_data, a_top;
    logic        a_valid, a_ovf, a_unf;
    logic [2:0]  a_count;
    logic [4:0]  a_ckpt_out, a_ckpt_in;

    // DEPTH=3 instance
    logic        b_rst, b_flush, b_push, b_pop, b_restore;
    logic [63:0] b_data, b_top;
    logic        b_valid, b_ovf, b_unf;
    logic [1:0]  b_count;
    logic [3:0]  b_ckpt_out, b_ckpt_in;

    ras_circ_stack #(.DEPTH(4), .VLEN(64)) dut_a (
        .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .push_i(a_push), .pop_i(a_pop),
        .data_i(a_data), .top_o(a_top), .top_valid_o(a_valid), .count_o(a_count),
        .overflow_o(a_ovf), .underflow_o(a_unf), .ckpt_o(a_ckpt_out),
        .restore_i(a_restore), .ckpt_i(a_ckpt_in)
    );

    ras_circ_stack #(.DEPTH(3), .VLEN(64)) dut_b (
        .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .push_i(b_push), .pop_i(b_pop),
        .data_i(b_data), .top_o(b_top), .top_valid_o(b_valid), .count_o(b_count),
        .overflow_o(b_ovf), .underflow_o(b_unf), .ckpt_o(b_ckpt_out),
        .restore_i(b_restore), .ckpt_i(b_ckpt_in)
    );

    // Restored snapshots must always be legal
    always @(posedge clk) begin
        if (a_restore) assert (a_ckpt_in[4:2] <= 3'd4);
        if (b_restore) assert (b_ckpt_in[3:2] <= 2'd3 && b_ckpt_in[1:0] < 2'd3);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_rst = 0; a_flush = 0; a_push = 0; a_pop = 0; a_restore = 0; a_data = '0; a_ckpt_in = '0;
    endtask

    task automatic b_idle();
        b_rst = 0; b_flush = 0; b_push = 0; b_pop = 0; b_restore = 0; b_data = '0; b_ckpt_in = '0;
    endtask

    task automatic a_push1(input logic [63:0] d);
        a_idle(); a_push = 1; a_data = d; tick(); a_idle();
    endtask

    task automatic b_push1(input logic [63:0] d);
        b_idle(); b_push = 1; b_data = d; tick(); b_idle();
    endtask

    initial begin
        a_idle(); b_idle();
        a_rst = 1; b_rst = 1;
        tick();
        a_idle(); b_idle();
        tick();

        // Reset state
        chk("rst_top",   a_top, 64'h0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_count", a_count, 3'd0);
        chk("rst_ovf",   a_ovf, 1'b0);
        chk("rst_unf",   a_unf, 1'b0);
        chk("rst_ckpt",  a_ckpt_out, 5'd0);

        // Basic push/pop with zero-latency top read
        a_push1(64'h100); a_push1(64'h200); a_push1(64'h300);
        chk("push3_top",   a_top, 64'h300);
        chk("push3_count", a_count, 3'd3);
        a_pop = 1;
        chk("pop_same_cycle_top", a_top, 64'h300);
        tick(); a_idle();
        chk("pop_top",   a_top, 64'h200);
        chk("pop_count", a_count, 3'd2);

        // Flush beats push
        a_flush = 1; a_push = 1; a_data = 64'h555;
        tick(); a_idle();
        chk("flush_count", a_count, 3'd0);
        chk("flush_valid", a_valid, 1'b0);

        // Replace on non-empty stack
        a_push1(64'h40);
        a_push = 1; a_pop = 1; a_data = 64'h80;
        tick(); a_idle();
        chk("replace_count", a_count, 3'd1);
        chk("replace_top",   a_top, 64'h80);

        // Replace on empty stack
        a_flush = 1; tick(); a_idle();
        a_push = 1; a_pop = 1; a_data = 64'h90;
        tick(); a_idle();
        chk("replace_empty_count", a_count, 3'd1);
        chk("replace_empty_top",   a_top, 64'h90);
        chk("replace_no_ovf",      a_ovf, 1'b0);
        chk("replace_no_unf",      a_unf, 1'b0);

        // Checkpoint: after flush tos=0; two pushes give {count=2, tos=2}
        a_flush = 1; tick(); a_idle();
        a_push1(64'h1); a_push1(64'h2);
        chk("ckpt_out", a_ckpt_out, CK_EN ? 5'b010_10 : 5'd0);
        a_pop = 1; tick(); a_idle();
        a_pop = 1; tick(); a_idle();
        a_push1(64'h5); a_push1(64'h7); a_push1(64'h9);
        chk("pre_restore_top", a_top, 64'h9);
        a_restore = 1; a_ckpt_in = 5'b010_10;
        tick(); a_idle();
        chk("restore_count", a_count, CK_EN ? 3'd2 : 3'd3);
        chk("restore_top",   a_top, CK_EN ? 64'h7 : 64'h9);

        // Restore with push in the same cycle: push is dropped when restore is built
        a_restore = 1; a_ckpt_in = 5'b001_01; a_push = 1; a_data = 64'hEE;
        tick(); a_idle();
        chk("restore_push_count", a_count, CK_EN ? 3'd1 : 3'd4);
        chk("restore_push_top",   a_top, CK_EN ? 64'h5 : 64'hEE);
        chk("restore_push_ckpt",  a_ckpt_out, CK_EN ? 5'b001_01 : 5'd0);

        // Mid-sequence reset with a push in the same cycle
        a_rst = 1; a_push = 1; a_data = 64'h1234;
        tick(); a_idle();
        chk("midrst_count", a_count, 3'd0);
        chk("midrst_valid", a_valid, 1'b0);
        chk("midrst_top",   a_top, 64'h0);
        chk("midrst_ckpt",  a_ckpt_out, 5'd0);

        // DEPTH=3 overflow
        b_push1(64'hA); b_push1(64'hB); b_push1(64'hC);
        chk("b_full_ovf", b_ovf, 1'b0);
        b_push1(64'hD);
        chk("b_ovf_pulse", b_ovf, 1'b1);
        chk("b_ovf_count", b_count, 2'd3);
        chk("b_ovf_top",   b_top, 64'hD);
        tick();
        chk("b_ovf_clear", b_ovf, 1'b0);

        // Three pops read D, C, B; the fourth underflows
        b_pop = 1;
        chk("b_pop1_top", b_top, 64'hD);
        tick();
        chk("b_pop2_top", b_top, 64'hC);
        tick();
        chk("b_pop3_top", b_top, 64'hB);
        tick();
        chk("b_empty_count", b_count, 2'd0);
        chk("b_empty_valid", b_valid, 1'b0);
        chk("b_empty_unf",   b_unf, 1'b0);
        tick(); b_idle();
        chk("b_unf_pulse", b_unf, 1'b1);
        chk("b_unf_count", b_count, 2'd0);
        tick();
        chk("b_unf_clear", b_unf, 1'b0);

        // Flush suppresses an underflowing pop
        b_flush = 1; b_pop = 1;
        tick(); b_idle();
        chk("b_flush_pop_unf", b_unf, 1'b0);

        // Reset suppresses an overflowing push
        b_push1(64'h11); b_push1(64'h22); b_push1(64'h33);
        chk("b_refill_count", b_count, 2'd3);
        b_rst = 1; b_push = 1; b_data = 64'h44;
        tick(); b_idle();
        chk("b_rst_ovf",   b_ovf, 1'b0);
        chk("b_rst_count", b_count, 2'd0);
        chk("b_rst_top",   b_top, 64'h0);

        // Restore on DEPTH=3 is ignored when not built
        b_push1(64'h66);
        b_restore = 1; b_ckpt_in = 4'b00_00;
        tick(); b_idle();
        chk("b_restore_count", b_count, CK_EN ? 2'd0 : 2'd1);
        chk("b_ckpt_out",      b_ckpt_out, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
